icache_ctrl: RTL and testbench

//  Direct-mapped instruction cache between the pipelined CPU fetch stage and a multi-cycle main memory.

---
 rtl/icache_pkg.sv | 36 +++
 rtl/icache_if.sv | 31 +++
 rtl/icache_tag_array.sv | 43 ++++
 rtl/icache_ctrl.sv | 140 ++++++++++++++
 tb/tb_icache_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: FSM state encoding, geometry helpers and line-base helper
// shared by the instruction cache files.
package icache_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w,
                               input int line_words,
                               input int num_lines);
    return addr_w - idx_w(num_lines) - off_w(line_words);
  endfunction

  function automatic logic [DEF_ADDR_W-1:0] line_base(
    input logic [DEF_ADDR_W-1:0] addr,
    input int                    ow
  );
    return addr & ({DEF_ADDR_W{1'b1}} << ow);
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-side signals of the instruction cache.
// slave = cache side; master = CPU fetch stage plus main memory.
interface icache_if
  import icache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              fetch_re;
  logic [ADDR_W-1:0] fetch_addr;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              stall;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_re, fetch_addr, flush,
    input  mem_gnt, mem_valid, mem_rdata,
    output instr, stall, mem_re, mem_addr
  );

  modport master (
    output fetch_re, fetch_addr, flush,
    output mem_gnt, mem_valid, mem_rdata,
    input  instr, stall, mem_re, mem_addr
  );
endinterface

// File: rtl/icache_tag_array.sv
// icache_tag_array: per-line valid bits and tag RAM with combinational
// compare (match), one write port (we) and one-cycle flash clear (clr).
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int IDX_W     = idx_w(DEF_NUM_LINES),
  parameter int TAG_W     = tag_w(DEF_ADDR_W, DEF_LINE_WORDS,
                                  DEF_NUM_LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             match,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];

  assign match = valid[rd_idx] && (tags[rd_idx] == rd_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && we && !clr) begin
      tags[wr_idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache, zero-latency hit, stall
// and in-order line refill on miss. Ports: clk, rst_n, bus (icache_if),
// plus hit_cnt/miss_cnt when ICACHE_STATS_EN is defined.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  logic [1:0]        state;
  logic [OFF_W-1:0]  cnt;
  logic              pend;
  logic              mem_re_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [DATA_W-1:0] data [NUM_LINES][LINE_WORDS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;
  logic             match;
  logic             hit;
  logic             start_miss;
  logic             tag_we;
  logic             tag_clr;

  assign idx  = bus.fetch_addr[OFF_W +: IDX_W];
  assign tag  = bus.fetch_addr[ADDR_W-1 -: TAG_W];
  assign off  = bus.fetch_addr[OFF_W-1:0];
  assign fidx = mem_addr_q[OFF_W +: IDX_W];
  assign ftag = mem_addr_q[ADDR_W-1 -: TAG_W];

  assign hit = (state == ST_IDLE) && match;
  assign start_miss = (state == ST_IDLE) && !bus.flush &&
                      bus.fetch_re && !hit;

  // A flush arriving in DONE also wins over validating the line.
  assign tag_clr = ((state == ST_IDLE) && bus.flush) ||
                   ((state == ST_DONE) && (pend || bus.flush));
  assign tag_we  = (state == ST_DONE) && !pend && !bus.flush;

  assign bus.instr    = hit ? data[idx][off] : '0;
  assign bus.stall    = (state != ST_IDLE) || (bus.fetch_re && !hit);
  assign bus.mem_re   = mem_re_q;
  assign bus.mem_addr = mem_addr_q;

  icache_tag_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_tags (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_idx (idx),
    .rd_tag (tag),
    .match  (match),
    .we     (tag_we),
    .wr_idx (fidx),
    .wr_tag (ftag),
    .clr    (tag_clr)
  );

  always_ff @(posedge clk) begin
    if (rst_n && (state == ST_FILL) && bus.mem_valid) begin
      data[fidx][cnt] <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_miss) begin
            state      <= ST_REQ;
            mem_re_q   <= 1'b1;
            mem_addr_q <= line_base(bus.fetch_addr, OFF_W);
          end
        end
        ST_REQ: begin
          if (bus.flush) pend <= 1'b1;
          if (bus.mem_gnt) begin
            state    <= ST_FILL;
            cnt      <= '0;
            mem_re_q <= 1'b0;
          end
        end
        ST_FILL: begin
          if (bus.flush) pend <= 1'b1;
          if (bus.mem_valid) begin
            cnt <= cnt + OFF_W'(1);
            if (cnt == LAST) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          pend  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (bus.fetch_re && hit) hit_cnt <= hit_cnt + 16'd1;
      if (start_miss) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: self-checking bench for icache_ctrl against a
// line-level cache model and a fixed memory image.
module tb_icache_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  icache_if bus ();

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  icache_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  logic [15:0] mem_img [65536];
  bit          m_valid [32];
  logic [15:0] m_base  [32];
  int          m_hits;
  int          m_miss;
  int          n_pass;
  int          n_chk;

  task automatic model_clear;
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.fetch_re  = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_gnt   = 1'b0;
    bus.mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    m_hits = 0;
    m_miss = 0;
  endtask

  // One fetch of address a; a miss is served from mem_img with `gap`
  // idle cycles before each beat, flush pulsed on beat fl_beat (if >=0).
  task automatic access(input logic [15:0] a, input int fl_beat,
                        input int gap);
    logic [15:0] base;
    int li;
    int drops;
    int w;
    base = a - (a % 16'd4);
    li = int'(a / 16'd4) % 32;
    bus.fetch_re = 1'b1;
    bus.fetch_addr = a;
    @(negedge clk);
    if (m_valid[li] && m_base[li] == base) begin
      n_chk++;
      if (bus.stall !== 1'b0 || bus.instr !== mem_img[a] ||
          bus.mem_re !== 1'b0)
        $display("FAIL hit a=%h: stall=%b instr=%h mem_re=%b, want 0/%h/0",
                 a, bus.stall, bus.instr, bus.mem_re, mem_img[a]);
      else n_pass++;
      m_hits++;
      @(posedge clk);
      #1;
      bus.fetch_re = 1'b0;
    end else begin
      n_chk++;
      if (bus.stall !== 1'b1 || bus.instr !== 16'h0)
        $display("FAIL miss_lookup a=%h: stall=%b instr=%h, want 1/0000",
                 a, bus.stall, bus.instr);
      else n_pass++;
      m_miss++;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_chk++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== base ||
          bus.stall !== 1'b1)
        $display("FAIL req a=%h: mem_re=%b mem_addr=%h stall=%b, want 1/%h/1",
                 a, bus.mem_re, bus.mem_addr, bus.stall, base);
      else n_pass++;
      drops = 0;
      w = $urandom_range(0, 2);
      repeat (w) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'($urandom);
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        if (bus.mem_re !== 1'b1 || bus.stall !== 1'b1) drops++;
      end
      bus.mem_gnt = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_gnt = 1'b0;
      bus.fetch_addr = 16'($urandom);
      @(negedge clk);
      n_chk++;
      if (bus.mem_re !== 1'b0 || bus.stall !== 1'b1)
        $display("FAIL gnt a=%h: mem_re=%b stall=%b, want 0/1",
                 a, bus.mem_re, bus.stall);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
        repeat (gap) begin
          bus.mem_rdata = 16'($urandom);
          @(posedge clk);
          #1;
          @(negedge clk);
          if (bus.stall !== 1'b1) drops++;
        end
        bus.mem_valid = 1'b1;
        bus.mem_rdata = mem_img[base + 16'(k)];
        bus.flush = (k == fl_beat);
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        if (bus.stall !== 1'b1 || bus.mem_re !== 1'b0) drops++;
      end
      bus.fetch_addr = a;
      n_chk++;
      if (drops != 0)
        $display("FAIL fill_hold a=%h: bad cycles=%0d, want 0", a, drops);
      else n_pass++;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_chk++;
      if (fl_beat < 0) begin
        if (bus.stall !== 1'b0 || bus.instr !== mem_img[a])
          $display("FAIL refill a=%h: stall=%b instr=%h, want 0/%h",
                   a, bus.stall, bus.instr, mem_img[a]);
        else n_pass++;
        m_valid[li] = 1'b1;
        m_base[li] = base;
      end else begin
        if (bus.stall !== 1'b1 || bus.instr !== 16'h0)
          $display("FAIL flushed_fill a=%h: stall=%b instr=%h, want 1/0000",
                   a, bus.stall, bus.instr);
        else n_pass++;
        model_clear();
      end
      bus.fetch_re = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    n_chk++;
    if (bus.stall !== 1'b0 || bus.mem_re !== 1'b0 ||
        bus.mem_addr !== 16'h0 || bus.instr !== 16'h0)
      $display("FAIL reset: stall=%b mem_re=%b mem_addr=%h instr=%h, want 0/0/0000/0000",
               bus.stall, bus.mem_re, bus.mem_addr, bus.instr);
    else n_pass++;
    bus.fetch_addr = 16'h0005;
    bus.fetch_re = 1'b1;
    #1;
    n_chk++;
    if (bus.stall !== 1'b1 || bus.instr !== 16'h0)
      $display("FAIL reset_lookup: stall=%b instr=%h, want 1/0000",
               bus.stall, bus.instr);
    else n_pass++;
    bus.fetch_re = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_miss;
    access(16'h0005, -1, 0);
  endtask

  task automatic test_back_to_back;
    access(16'h0004, -1, 0);
    access(16'h0007, -1, 0);
  endtask

  task automatic test_conflict;
    access(16'h0000, -1, 0);
    access(16'h0080, -1, 1);
    access(16'h0000, -1, 0);
    access(16'h0001, -1, 0);
  endtask

  task automatic test_flush_mid_fill;
    access(16'h0100, 1, 1);
    access(16'h0100, -1, 0);
    access(16'h0102, -1, 0);
  endtask

  task automatic test_flush_idle;
    access(16'h0200, -1, 0);
    bus.fetch_re = 1'b1;
    bus.fetch_addr = 16'h0384;
    bus.flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.stall !== 1'b1)
      $display("FAIL flush_idle_lookup: stall=%b, want 1", bus.stall);
    else n_pass++;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.fetch_re = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.mem_re !== 1'b0 || bus.stall !== 1'b0)
      $display("FAIL flush_priority: mem_re=%b stall=%b, want 0/0",
               bus.mem_re, bus.stall);
    else n_pass++;
    model_clear();
    @(posedge clk);
    #1;
    access(16'h0200, -1, 0);
  endtask

  task automatic test_reset_mid_fill;
    bus.fetch_re = 1'b1;
    bus.fetch_addr = 16'h0040;
    @(negedge clk);
    n_chk++;
    if (bus.stall !== 1'b1)
      $display("FAIL rmf_miss: stall=%b, want 1", bus.stall);
    else n_pass++;
    @(posedge clk);
    #1;
    bus.fetch_re = 1'b0;
    bus.mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_gnt = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.stall !== 1'b0 || bus.mem_re !== 1'b0 ||
          bus.mem_addr !== 16'h0)
        $display("FAIL rmf_idle%0d: stall=%b mem_re=%b mem_addr=%h, want 0/0/0000",
                 i, bus.stall, bus.mem_re, bus.mem_addr);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    bus.mem_valid = 1'b0;
    model_clear();
    m_hits = 0;
    m_miss = 0;
    access(16'h0040, -1, 0);
    access(16'h0004, -1, 0);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats;
    @(negedge clk);
    n_chk++;
    if (hit_cnt !== 16'(m_hits) || miss_cnt !== 16'(m_miss))
      $display("FAIL stats: hit_cnt=%0d miss_cnt=%0d, want %0d/%0d",
               hit_cnt, miss_cnt, m_hits, m_miss);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask
`endif

  task automatic test_wrap_gaps;
    do_reset();
    access(16'hFFFE, -1, 2);
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
  endtask

  task automatic test_random;
    logic [15:0] a;
    int fl;
    for (int i = 0; i < 60; i++) begin
      a = 16'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) |
              $urandom_range(0, 3));
      fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      access(a, fl, int'($urandom_range(0, 2)));
    end
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
  endtask

  initial begin
    n_pass = 0;
    n_chk = 0;
    m_hits = 0;
    m_miss = 0;
    for (int i = 0; i < 65536; i++) mem_img[i] = 16'($urandom);
    mem_img[4] = 16'h1111;
    mem_img[5] = 16'h2222;
    mem_img[6] = 16'h3333;
    mem_img[7] = 16'h4444;
    bus.fetch_re   = 1'b0;
    bus.fetch_addr = 16'h0;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_valid  = 1'b0;
    bus.mem_rdata  = 16'h0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_flush_mid_fill();
    test_flush_idle();
    test_reset_mid_fill();
    test_wrap_gaps();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
